// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream width converters.
package stream_pkg;

  typedef enum logic {FILL, HOLD} upsizer_state_e;

  function automatic int lane_count_width(input int ratio);
    return $clog2(ratio);
  endfunction

endpackage

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow beats (lane 0 first) into one wide word; w_last flushes a partial word.
// Define STREAM_UPSIZER_OVERLAP_EN to let a new beat enter in the same cycle the held word leaves.
module stream_upsizer
  import stream_pkg::*;
#(
  parameter  int IN_WIDTH  = 8,
  parameter  int RATIO     = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [IN_WIDTH-1:0]  w_data,
  input  logic                 w_last,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [OUT_WIDTH-1:0] r_data,
  output logic [RATIO-1:0]     r_keep,
  output logic                 r_last
);

  localparam int CW = lane_count_width(RATIO);

  if (RATIO < 2) begin : g_ratio_check
    $fatal(1, "stream_upsizer: RATIO must be at least 2");
  end

  upsizer_state_e       state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [RATIO-1:0]     keep_q, keep_d;
  logic                 last_q, last_d;
  logic                 w_fire, r_fire;

`ifdef STREAM_UPSIZER_OVERLAP_EN
  // Combinational ready path: a held word leaving frees the buffer for this cycle's beat.
  assign w_ready = (state_q == FILL) || r_ready;
`else
  assign w_ready = (state_q == FILL);
`endif

  assign r_valid = (state_q == HOLD);
  assign r_data  = data_q;
  assign r_keep  = keep_q;
  assign r_last  = last_q;
  assign w_fire  = w_valid && w_ready;
  assign r_fire  = r_valid && r_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    case (state_q)
      FILL: begin
        if (w_fire) begin
          data_d[cnt_q*IN_WIDTH +: IN_WIDTH] = w_data;
          keep_d[cnt_q] = 1'b1;
          cnt_d         = cnt_q + CW'(1);
          if (cnt_q == CW'(RATIO - 1) || w_last) begin
            state_d = HOLD;
            last_d  = w_last;
            cnt_d   = '0;
          end
        end
      end
      HOLD: begin
        if (r_fire) begin
          data_d  = '0;
          keep_d  = '0;
          last_d  = 1'b0;
          state_d = FILL;
`ifdef STREAM_UPSIZER_OVERLAP_EN
          if (w_fire) begin
            data_d[IN_WIDTH-1:0] = w_data;
            keep_d[0]            = 1'b1;
            if (w_last) begin
              state_d = HOLD;
              last_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = CW'(1);
            end
          end
`endif
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

endmodule
